// File: rtl/c17_bist_ctrl.sv
// c17_bist_ctrl: built-in self-test sequencer for the c17 benchmark netlist.
// The pattern generator applies one all-zero pattern and then a 5-bit maximal
// LFSR sequence to the c17 inputs. The two c17 outputs are compacted into an
// 8-bit MISR, and the final signature is compared against GOLDEN.
module c17_bist_ctrl #(
  parameter int unsigned N_PAT  = 32,
  parameter logic [4:0]  SEED   = 5'h01,
  parameter logic [7:0]  GOLDEN = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] resp_in,
  output logic [4:0] pat_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] sig_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CMP  = 2'd2
  } state_e;

  // This is the value cnt holds during the cycle that presents the last pattern.
  localparam logic [5:0] LAST_CNT = 6'(N_PAT - 32'd1);

  state_e     state_q;
  logic [4:0] pat_q;
  logic [7:0] misr_q;
  logic [5:0] cnt_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;

  logic [7:0] misr_d;
  logic [4:0] pat_d;
  logic       last_s;

  // MISR feedback taps: x^8 + x^6 + x^5 + x^4 + 1
  function automatic logic misr_fb(input logic [7:0] m);
    return m[7] ^ m[5] ^ m[4] ^ m[3];
  endfunction

  // Pattern LFSR step: x^5 + x^3 + 1. It never maps a nonzero state to zero.
  function automatic logic [4:0] lfsr_step(input logic [4:0] p);
    return {p[3:0], p[4] ^ p[2]};
  endfunction

  // Next MISR value, next pattern, and the last-pattern flag.
  always_comb begin
    misr_d = {misr_q[6:0], misr_fb(misr_q)} ^ {6'b0, resp_in};
    if (pat_q == 5'd0) begin
      pat_d = SEED;
    end else begin
      pat_d = lfsr_step(pat_q);
    end
    last_s = (cnt_q == LAST_CNT);
  end

  // Sequencer FSM with registered pattern, signature and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pat_q   <= 5'd0;
      misr_q  <= 8'd0;
      cnt_q   <= 6'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= ST_RUN;
            pat_q   <= 5'd0;
            misr_q  <= 8'd0;
            cnt_q   <= 6'd0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          // Capture the response to the pattern currently on pat_out.
          misr_q <= misr_d;
          cnt_q  <= cnt_q + 6'd1;
          if (last_s) begin
            // The compare uses the final signature, so pass is already
            // valid in the cycle where done is high. pat_out holds here.
            state_q <= ST_CMP;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (misr_d == GOLDEN);
          end else begin
            state_q <= ST_RUN;
            pat_q   <= pat_d;
          end
        end
        ST_CMP: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pat_out = pat_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign sig_out = misr_q;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Self-checking bench for c17_bist_ctrl with a behavioural c17 model beside
// the DUT. Expected patterns are queued when a run starts and popped per RUN cycle.
module tb_c17_bist_ctrl;

  // Reference c17: the six-NAND benchmark netlist.
  function automatic logic [1:0] c17(input logic [4:0] p);
    logic g1, g2, g3, g6, g7, n10, n11, n16, n19;
    g1 = p[4]; g2 = p[3]; g3 = p[2]; g6 = p[1]; g7 = p[0];
    n10 = ~(g1 & g3);
    n11 = ~(g3 & g6);
    n16 = ~(g2 & n11);
    n19 = ~(n11 & g7);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

  // Reference signature over a full 32-pattern run, with optional gat_out22 stuck at 1.
  function automatic logic [7:0] model_sig(input logic stuck22);
    logic [7:0] m;
    logic [4:0] p;
    logic [1:0] r;
    m = 8'd0;
    p = 5'd0;
    for (int i = 0; i < 32; i++) begin
      r = c17(p);
      if (stuck22) r[1] = 1'b1;
      m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]} ^ {6'b0, r};
      p = (p == 5'd0) ? 5'h01 : {p[3:0], p[4] ^ p[2]};
    end
    return m;
  endfunction

  localparam logic [7:0] GOLD = model_sig(1'b0);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       ovr_en, stuck;
  logic [1:0] ovr_val;
  logic [4:0] pat0, pat1;
  logic [1:0] c17_0, resp0, resp1;
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [7:0] sig0, sig1;

  int checks = 0;
  int failures = 0;
  logic [4:0] exp_q[$];
  logic [31:0] seen;

  always #5 clk = ~clk;

  assign c17_0 = c17(pat0);
  assign resp0 = ovr_en ? ovr_val : (stuck ? {1'b1, c17_0[0]} : c17_0);
  assign resp1 = c17(pat1);

  c17_bist_ctrl #(.N_PAT(32), .SEED(5'h01), .GOLDEN(GOLD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .resp_in(resp0),
    .pat_out(pat0), .busy(busy0), .done(done0), .pass(pass0), .sig_out(sig0)
  );

  c17_bist_ctrl #(.N_PAT(32), .SEED(5'h01), .GOLDEN(GOLD ^ 8'h01)) dut_bad (
    .clk(clk), .rst_n(rst_n), .start(start), .resp_in(resp1),
    .pat_out(pat1), .busy(busy1), .done(done1), .pass(pass1), .sig_out(sig1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_queue();
    logic [4:0] p;
    exp_q.delete();
    p = 5'd0;
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(p);
      p = (p == 5'd0) ? 5'h01 : {p[3:0], p[4] ^ p[2]};
    end
  endtask

  // Single-cycle start; returns at the falling edge of the first RUN cycle.
  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Watch a run for 45 cycles starting at RUN cycle 1 (c=0), popping the scoreboard.
  task automatic run_monitor(input int inj_a, input int inj_b,
                             output int busy_cnt, output int done_cnt, output int done_cyc,
                             output logic pass_d, output logic [7:0] sig_d, output logic pass1_d);
    busy_cnt = 0; done_cnt = 0; done_cyc = -1;
    pass_d = 1'b0; sig_d = 8'd0; pass1_d = 1'b0;
    seen = 32'd0;
    for (int c = 0; c < 45; c++) begin
      start = (c == inj_a) || (c == inj_b);
      if (busy0) begin
        busy_cnt++;
        seen[pat0] = 1'b1;
        if (exp_q.size() > 0) chk("pat_seq", {27'd0, pat0}, {27'd0, exp_q.pop_front()});
        else chk("pat_extra", 32'd1, 32'd0);
      end
      if (done0) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          pass_d = pass0;
          sig_d = sig0;
          pass1_d = pass1;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  int bc, dc, dcy, nd, nb;
  logic pd, p1d;
  logic [7:0] sd;

  initial begin
    rst_n = 1'b0; start = 1'b0; ovr_en = 1'b0; ovr_val = 2'b00; stuck = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pat", {27'd0, pat0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_pass", {31'd0, pass0}, 32'd0);
    chk("rst_sig", {24'd0, sig0}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", {31'd0, busy0}, 32'd0);

    // Compaction unit check: 01 on the first RUN cycle, 00 afterwards.
    ovr_en = 1'b1; ovr_val = 2'b01;
    start_pulse();
    chk("unit_pat0", {27'd0, pat0}, 32'd0);
    chk("unit_busy", {31'd0, busy0}, 32'd1);
    @(negedge clk);
    chk("unit_sig1", {24'd0, sig0}, 32'h01);
    ovr_val = 2'b00;
    @(negedge clk);
    chk("unit_sig2", {24'd0, sig0}, 32'h02);
    repeat (40) @(negedge clk);
    ovr_en = 1'b0;

    // Full run on the c17 model with stray starts in RUN (c=10) and CMP (c=32).
    build_queue();
    start_pulse();
    run_monitor(10, 32, bc, dc, dcy, pd, sd, p1d);
    chk("full_busy_cycles", bc, 32);
    chk("full_done_count", dc, 1);
    chk("full_done_cycle", dcy, 32);
    chk("full_pass", {31'd0, pd}, 32'd1);
    chk("full_sig", {24'd0, sd}, {24'd0, GOLD});
    chk("full_all_patterns", seen, 32'hFFFF_FFFF);
    chk("full_queue_empty", exp_q.size(), 0);
    chk("pass_held", {31'd0, pass0}, 32'd1);
    chk("bad_golden_pass", {31'd0, p1d}, 32'd0);

    // Fault injection: gat_out22 stuck at 1.
    stuck = 1'b1;
    build_queue();
    start_pulse();
    chk("pass_cleared_on_start", {31'd0, pass0}, 32'd0);
    run_monitor(-1, -1, bc, dc, dcy, pd, sd, p1d);
    chk("fault_done_count", dc, 1);
    chk("fault_pass", {31'd0, pd}, 32'd0);
    chk("fault_sig", {24'd0, sd}, {24'd0, model_sig(1'b1)});
    chk("fault_sig_differs", {31'd0, (sd != GOLD)}, 32'd1);
    stuck = 1'b0;

    // Asynchronous reset in the middle of RUN cycle 10.
    start_pulse();
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy0}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pat", {27'd0, pat0}, 32'd0);
    chk("async_busy", {31'd0, busy0}, 32'd0);
    chk("async_sig", {24'd0, sig0}, 32'd0);
    chk("async_done", {31'd0, done0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0; nb = 0;
    for (int c = 0; c < 45; c++) begin
      if (done0) nd++;
      if (busy0) nb++;
      @(negedge clk);
    end
    chk("no_done_after_rst", nd, 0);
    chk("no_busy_after_rst", nb, 0);

    build_queue();
    start_pulse();
    run_monitor(-1, -1, bc, dc, dcy, pd, sd, p1d);
    chk("rerun_busy_cycles", bc, 32);
    chk("rerun_done_cycle", dcy, 32);
    chk("rerun_pass", {31'd0, pd}, 32'd1);
    chk("rerun_sig", {24'd0, sd}, {24'd0, GOLD});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/c17_bist_ctrl.md
Name: c17_bist_ctrl

Overview:
- Built-in self-test sequencer for the c17 combinational benchmark netlist.
- Drives the five c17 primary inputs from a pattern generator: one all-zero pattern followed by a 5-bit maximal LFSR.
- Compacts the two c17 outputs into an 8-bit MISR each cycle.
- At the end of a run, compares the signature against a golden value and reports pass/fail.
- Sits beside the c17 instance in the test wrapper; c17 stays purely combinational between pat_out and resp_in.

Parameters:
- N_PAT, 32, number of patterns applied per run (1..32). 32 gives an exhaustive input space.
- SEED, 5'h01, LFSR value loaded as pattern index 1 (must be nonzero).
- GOLDEN, 8'h00, expected MISR signature. Set per netlist from the bench reference model.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle run request; sampled only in IDLE
- resp_in  in  2  c17 outputs: [1]=gat_out22, [0]=gat_out23
- pat_out  out  5  c17 inputs, registered: [4]=gat1, [3]=gat2, [2]=gat3, [1]=gat6, [0]=gat7
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when the signature is final
- pass  out  1  compare result; valid from the done cycle and held until the next start
- sig_out  out  8  current MISR value (registered)

Behaviour:
- One clock domain; reset is asynchronous and active-low (rst_n). Reset values: state=IDLE, pat_out=0, busy=0, done=0, pass=0, sig_out=0, pattern counter=0.
- States: IDLE, RUN, CMP.
- IDLE: if start=1, go to RUN next cycle. On that edge: pat_out<=0, misr<=0, cnt<=0, pass<=0.
- RUN: busy=1. Every cycle:
  - misr <= {misr[6:0], fb} ^ {6'b0, resp_in}, where fb = misr[7]^misr[5]^misr[4]^misr[3].
  - Pattern advance: if pat_out==0 then pat_out<=SEED; else pat_out <= {pat_out[3:0], pat_out[4]^pat_out[2]} (x^5+x^3+1).
  - cnt<=cnt+1.
- RUN exit: after the capture at cnt==N_PAT-1, go to CMP. pat_out holds its last value; it does not advance on the exit edge.
- Response timing: resp_in is sampled in the same cycle pat_out is presented (zero-cycle combinational path through c17). Exactly N_PAT responses are absorbed.
- CMP: one cycle. done=1, pass<=(misr==GOLDEN). Next state IDLE.
- Latency: start sampled at edge T → busy high T+1..T+N_PAT → done high in cycle T+N_PAT+1.
- start while in RUN or CMP: ignored, no restart.
- start in the cycle after CMP: accepted normally. pass is cleared on the accepting edge.
- rst_n asserted mid-run: immediate return to reset values; no done pulse. A new start is required.
- cnt is 6 bits, so no wrap inside a run. The LFSR never reaches 0 after SEED, so pattern 0 appears exactly once per run.
- sig_out mirrors misr continuously, including during RUN, for debug.

Test Plan:
- Reset: hold rst_n=0 asynchronously mid-cycle → all outputs 0 immediately, state IDLE. busy stays 0 with no start.
- Pattern sequence: start with SEED=5'h01 → pat_out over consecutive RUN cycles = 00000, 00001, 00010, 00100, 01001, 10010. After 32 patterns every 5-bit value has appeared exactly once.
- Compaction unit check: with resp_in forced to 2'b01 for the first RUN cycle only and 2'b00 afterwards → sig_out=8'h01 after cycle 1, 8'h02 after cycle 2. All-zero pattern on real c17 yields resp_in=2'b00.
- Full run on real c17: N_PAT=32, GOLDEN from the reference model → busy high exactly 32 cycles, done one-cycle pulse at T+33, pass=1. Rerun with GOLDEN^8'h01 → pass=0.
- Fault injection: stick gat_out22 at 1 during the run → final sig_out differs from GOLDEN, pass=0.
- Control corners: start pulses during RUN and CMP are ignored (done count=1). rst_n pulse at RUN cycle 10 → no done; subsequent start gives a clean full run with pass=1.
